// File: rtl/enc_pkg.sv
// Shared types for the one-hot/multi-hot serial encoder family.
package enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } enc_state_e;

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder; also reports "any bit set"
// and "exactly one bit set".
module lsb_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any,
  output logic                 single
);

  localparam int IDX_W = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/onehot_serial_encoder.sv
// Serialises a multi-hot request vector into binary indices, lowest bit first,
// with valid/ready on both sides and no idle cycle between vectors.
module onehot_serial_encoder
  import enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  enc_state_e       state, state_nx;
  logic [N-1:0]     pend, pend_nx;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any, enc_single;
  logic             beat, fin, acc_nz;

  lsb_prio_enc #(.N(N)) u_enc (
    .vec    (pend),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  assign beat   = (state == DRAIN) && enc_any && out_ready;
  assign fin    = beat && enc_single;
  assign acc_nz = in_valid && in_ready && (in_vec != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    case (state)
      IDLE: begin
        if (acc_nz) begin
          state_nx = DRAIN;
          pend_nx  = in_vec;
        end
      end
      DRAIN: begin
        // A new vector can be loaded in the same cycle the last index leaves.
        if (fin) begin
          state_nx = acc_nz ? DRAIN : IDLE;
          pend_nx  = acc_nz ? in_vec : '0;
        end else if (beat) begin
          pend_nx = pend & ~(ONE << enc_idx);
        end
      end
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || fin;
    out_valid = (state == DRAIN);
    busy      = (state == DRAIN);
    out_idx   = (state == DRAIN) ? enc_idx : '0;
    out_last  = (state == DRAIN) && enc_single;
  end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Randomised and directed bench for onehot_serial_encoder against a
// queue-of-pending-indices reference model.
module tb_onehot_serial_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int q[$];
  int seen[$];
  int bcnt;

  onehot_serial_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    check({tag, "_len"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      check(tag, seen[i], exp[i]);
    seen.delete();
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic cycle(input logic v, input logic [7:0] vec, input logic ordy);
    int exp_valid, exp_idx, exp_last, exp_rdy;
    in_valid  = v;
    in_vec    = vec;
    out_ready = ordy;
    exp_valid = (q.size() > 0);
    exp_idx   = exp_valid ? q[0] : 0;
    exp_last  = (q.size() == 1);
    exp_rdy   = (q.size() == 0) || (ordy && q.size() == 1);
    @(negedge clk);
    check("out_valid", out_valid, exp_valid);
    check("busy", busy, exp_valid);
    check("out_idx", out_idx, exp_idx);
    check("out_last", out_last, exp_last);
    check("in_ready", in_ready, exp_rdy);
    if (busy) bcnt++;
    if (out_valid && out_ready) seen.push_back(int'(out_idx));
    @(posedge clk);
    if (q.size() > 0 && ordy) void'(q.pop_front());
    if (v && exp_rdy)
      for (int i = 0; i < 8; i++)
        if (vec[i]) q.push_back(i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int e[$];
    logic [7:0] rv;
    rst_n = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single bit
    cycle(1'b1, 8'b0000_0001, 1'b1);
    idle(2);
    e = '{0}; check_seq("single", e);

    // multi-bit order and busy length
    bcnt = 0;
    cycle(1'b1, 8'b1010_0110, 1'b1);
    idle(5);
    e = '{1, 2, 5, 7}; check_seq("multi", e);
    check("multi_busy", bcnt, 4);

    // backpressure
    cycle(1'b1, 8'b1000_1000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'hFF, 1'b0);
    idle(3);
    e = '{3, 7}; check_seq("bp", e);

    // zero vector accepted on the final beat, then a new vector from IDLE
    cycle(1'b1, 8'b0001_0000, 1'b1);
    cycle(1'b1, 8'b0000_0000, 1'b1);
    cycle(1'b1, 8'b1000_0001, 1'b1);
    idle(3);
    e = '{4, 0, 7}; check_seq("zero", e);

    // true back-to-back
    bcnt = 0;
    cycle(1'b1, 8'b0000_0100, 1'b1);
    cycle(1'b1, 8'b0100_0000, 1'b1);
    idle(2);
    e = '{2, 6}; check_seq("b2b", e);
    check("b2b_busy", bcnt, 2);

    // reset in the middle of a drain
    cycle(1'b1, 8'hFF, 1'b1);
    idle(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle(4);
    e = '{0, 1, 2}; check_seq("mid_rst", e);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = 8'h00;
        1:       rv = 8'(1) << $urandom_range(0, 7);
        default: rv = 8'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 9) < 7));
    end
    idle(10);
    check("rnd_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
